// File: rtl/alu_share_pkg.sv
// Shared definitions for the arbitrated ALU front end.
// Holds the opcode encodings and the controller state encoding.
package alu_share_pkg;

   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_AND = 2'd1;
   localparam logic [1:0] OP_NOT = 2'd2;
   localparam logic [1:0] OP_ILL = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

endpackage

// File: rtl/alu32.sv
// 32-bit add/and/not datapath, purely combinational (zero latency).
// No handshake: the caller holds the operands stable for as long as it needs the result.
module alu32
   import alu_share_pkg::*;
(
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   input  logic [1:0]  i_op,
   output logic [31:0] o_result,
   output logic        o_carry
);

   always_comb begin
      o_result = 32'd0;
      o_carry  = 1'b0;
      case (i_op)
         OP_ADD:  {o_carry, o_result} = {1'b0, i_a} + {1'b0, i_b};
         OP_AND:  o_result = i_a & i_b;
         OP_NOT:  o_result = ~i_a;
         default: o_result = 32'd0;
      endcase
   end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first set request at or after i_ptr, wrapping.
// Zero latency; the grant is all-zero when i_en is low, and the pointer is owned by the parent.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [ID_W-1:0]    i_ptr,
   input  logic               i_en,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic [ID_W-1:0]    o_gnt_idx
);

   logic [ID_W:0] w_pos;
   logic          w_found;

   always_comb begin
      o_gnt     = '0;
      o_gnt_idx = '0;
      w_pos     = '0;
      w_found   = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         // Extra bit on w_pos lets the wrap work for non-power-of-two NUM_REQ.
         w_pos = {1'b0, i_ptr} + (ID_W+1)'(k);
         if (w_pos >= (ID_W+1)'(NUM_REQ))
            w_pos = w_pos - (ID_W+1)'(NUM_REQ);
         if (i_en && !w_found && i_req[w_pos[ID_W-1:0]]) begin
            w_found                 = 1'b1;
            o_gnt[w_pos[ID_W-1:0]]  = 1'b1;
            o_gnt_idx               = w_pos[ID_W-1:0];
         end
      end
   end

endmodule

// File: rtl/alu_share_ctrl.sv
// One ALU shared by NUM_REQ requesters: round-robin accept, one execute cycle, tagged response.
// Response appears two cycles after accept and is held until rsp_ready; no new accept while busy.
module alu_share_ctrl
   import alu_share_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic [NUM_REQ*32-1:0] req_a,
   input  logic [NUM_REQ*32-1:0] req_b,
   input  logic [NUM_REQ*2-1:0]  req_op,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [ID_W-1:0]       rsp_id,
   output logic [31:0]           rsp_result,
   output logic                  rsp_carry,
   output logic                  rsp_err,
   output logic                  busy
);

   state_t              r_state, w_state_nxt;
   logic [ID_W-1:0]     r_rr_ptr, r_id, w_gnt_idx;
   logic [NUM_REQ-1:0]  w_gnt;
   logic [31:0]         r_a, r_b, w_sel_a, w_sel_b, w_alu_res;
   logic [1:0]          r_op, w_sel_op, w_alu_op;
   logic                w_alu_carry, w_arb_en, w_accept, w_rsp_hs;

   assign w_arb_en  = (r_state == ST_IDLE) && !rst;
   assign req_ready = w_gnt;
   assign w_accept  = |w_gnt;
   assign w_rsp_hs  = (r_state == ST_RESP) && rsp_ready;
   assign rsp_valid = (r_state == ST_RESP);
   assign busy      = (r_state != ST_IDLE);

   rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
      .i_req     (req_valid),
      .i_ptr     (r_rr_ptr),
      .i_en      (w_arb_en),
      .o_gnt     (w_gnt),
      .o_gnt_idx (w_gnt_idx)
   );

   always_comb begin
      w_sel_a  = '0;
      w_sel_b  = '0;
      w_sel_op = OP_ADD;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_gnt[i]) begin
            w_sel_a  = req_a[32*i +: 32];
            w_sel_b  = req_b[32*i +: 32];
            w_sel_op = req_op[2*i +: 2];
         end
      end
   end

   // Illegal opcodes still run the ALU as an add; the result is squashed at capture.
   assign w_alu_op = (r_op == OP_ILL) ? OP_ADD : r_op;

   alu32 u_alu (
      .i_a      (r_a),
      .i_b      (r_b),
      .i_op     (w_alu_op),
      .o_result (w_alu_res),
      .o_carry  (w_alu_carry)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_accept) w_state_nxt = ST_EXEC;
         ST_EXEC: w_state_nxt = ST_RESP;
         ST_RESP: if (rsp_ready) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_rr_ptr   <= '0;
         r_a        <= '0;
         r_b        <= '0;
         r_op       <= OP_ADD;
         r_id       <= '0;
         rsp_id     <= '0;
         rsp_result <= '0;
         rsp_carry  <= 1'b0;
         rsp_err    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_a  <= w_sel_a;
            r_b  <= w_sel_b;
            r_op <= w_sel_op;
            r_id <= w_gnt_idx;
         end
         if (r_state == ST_EXEC) begin
            rsp_id     <= r_id;
            rsp_result <= (r_op == OP_ILL) ? 32'd0 : w_alu_res;
            rsp_carry  <= (r_op == OP_ADD) && w_alu_carry;
            rsp_err    <= (r_op == OP_ILL);
         end
         if (w_rsp_hs)
            r_rr_ptr <= (rsp_id == ID_W'(NUM_REQ-1)) ? '0 : rsp_id + ID_W'(1);
      end
   end

endmodule
